// File: rtl/heavy_part_pkg.sv
// heavy_part_pkg
// Shared definitions for the heavy-part table pipeline stages:
//   - bucket address width and eviction threshold defaults
//   - bucket field offsets and the packed bucket layout (96 bits)
//   - the 128-bit read-stage record and 96-bit downstream record layouts
//   - INIT/RUN state encoding for the compare stages
//   - bucket_addr(): bucket index taken from key[15:4]
package heavy_part_pkg;

   localparam int HP_ADDR_W = 12;
   localparam int HP_LAMBDA = 8;
   localparam int HP_RD_LAT = 2;

   // Bucket field offsets inside the 96-bit RAM word
   localparam int BKT_W        = 96;
   localparam int BKT_KEY_LSB  = 64;
   localparam int BKT_POS_LSB  = 32;
   localparam int BKT_FLAG_BIT = 31;
   localparam int BKT_NEG_LSB  = 0;

   typedef struct packed {
      logic [31:0] key;
      logic [31:0] vote_pos;
      logic        flag;
      logic [30:0] vote_neg;
   } bucket_t;

   // Record issued by the read stage
   typedef struct packed {
      logic [63:0] time_stamp;
      logic [31:0] key;
      logic [31:0] value;
   } in_rec_t;

   // Record forwarded to the next table
   typedef struct packed {
      logic [31:0] key;
      logic [31:0] value;
      logic [31:0] time_lo;
   } out_rec_t;

   // Compare-stage FSM encoding
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic [HP_ADDR_W-1:0] bucket_addr(input logic [31:0] key);
      return key[HP_ADDR_W+3:4];
   endfunction

endpackage

// File: rtl/heavy_part_bucket_update.sv
// heavy_part_bucket_update
// Purely combinational Elastic-Sketch vote/evict rule for one bucket.
// Ports:
//   bucket     in  96  effective bucket {key, vote_pos, flag, vote_neg}
//   key        in  32  incoming flow key
//   value      in  32  incoming flow value
//   new_bucket out 96  bucket to write back
//   fwd_valid  out 1   a flow is displaced or rejected
//   fwd_key    out 32  key of the forwarded flow
//   fwd_value  out 32  value of the forwarded flow
module heavy_part_bucket_update
   import heavy_part_pkg::*;
#(
   parameter int LAMBDA = HP_LAMBDA
)(
   input  logic [95:0] bucket,
   input  logic [31:0] key,
   input  logic [31:0] value,
   output logic [95:0] new_bucket,
   output logic        fwd_valid,
   output logic [31:0] fwd_key,
   output logic [31:0] fwd_value
);

   // LAMBDA is a power of two, so the threshold is a left shift
   localparam int LSH = $clog2(LAMBDA);

   bucket_t     b;
   bucket_t     nb;
   logic [32:0] pos_sum;
   logic [31:0] pos_sat;
   logic [32:0] neg_sum;
   logic [30:0] neg_sat;
   logic [34:0] neg_ext;
   logic [34:0] thresh;

   assign b = bucket_t'(bucket);

   always_comb begin
      pos_sum = {1'b0, b.vote_pos} + {1'b0, value};
      pos_sat = pos_sum[32] ? 32'hFFFF_FFFF : pos_sum[31:0];
      neg_sum = {2'b00, b.vote_neg} + {1'b0, value};
      // Anything at or above 2^31 clamps to the 31-bit maximum
      neg_sat = (neg_sum[32:31] != 2'b00) ? 31'h7FFF_FFFF : neg_sum[30:0];
      // Compare in 35 bits so LAMBDA*vote_pos never wraps
      neg_ext = {4'b0000, neg_sat};
      thresh  = {3'b000, b.vote_pos} << LSH;

      nb        = b;
      fwd_valid = 1'b0;
      fwd_key   = key;
      fwd_value = value;

      if (b.vote_pos == 32'd0) begin
         nb.key      = key;
         nb.vote_pos = value;
         nb.flag     = 1'b0;
         nb.vote_neg = 31'd0;
      end else if (b.key == key) begin
         nb.vote_pos = pos_sat;
      end else if (neg_ext >= thresh) begin
         // Eviction: resident flow goes downstream, newcomer takes over
         nb.key      = key;
         nb.vote_pos = value;
         nb.flag     = 1'b1;
         nb.vote_neg = 31'd1;
         fwd_valid   = 1'b1;
         fwd_key     = b.key;
         fwd_value   = b.vote_pos;
      end else begin
         nb.vote_neg = neg_sat;
         fwd_valid   = 1'b1;
      end
   end

   assign new_bucket = nb;

endmodule

// File: rtl/heavy_part_table_compare1.sv
// heavy_part_table_compare1
// Second stage of heavy-part table 1: applies the vote/evict rule to the
// bucket RAM1 returns, writes it back, and forwards displaced/rejected flows
// to the table-2 FIFO. Zeroes RAM1 after reset before accepting traffic.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ip_addr_in_wr1      record valid from the read stage (same cycle as RAM read)
//   ip_addr_in1         {time[63:0], key[31:0], value[31:0]}
//   ip_addr_in_alf1     backpressure to the read stage
//   ram_rdata1          bucket from RAM1, valid RD_LAT cycles after the read
//   ram_wren1/wraddr1/wdata1  RAM1 write port
//   ip_addr_out_wr1     write strobe to the table-2 FIFO
//   ip_addr_out1        {key, value, time[31:0]}
//   ip_addr_out_alf1    almost-full from the table-2 FIFO
// Flow control: there is no ready signal. A record is taken whenever
// ip_addr_in_wr1 is high in RUN; the upstream stage must not issue while
// ip_addr_in_alf1 is high. The output strobe is fire-and-forget, relying on
// FIFO headroom for records already in flight when almost-full rises.
module heavy_part_table_compare1 #(
   parameter int LAMBDA = 8,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              ip_addr_in_wr1,
   input  logic [127:0]      ip_addr_in1,
   output logic              ip_addr_in_alf1,
   input  logic [95:0]       ram_rdata1,
   output logic              ram_wren1,
   output logic [ADDR_W-1:0] ram_wraddr1,
   output logic [95:0]       ram_wdata1,
   output logic              ip_addr_out_wr1,
   output logic [95:0]       ip_addr_out1,
   input  logic              ip_addr_out_alf1
);

   import heavy_part_pkg::*;

   logic [0:0]        state;
   logic [ADDR_W-1:0] init_addr;

   // Record delay line; the last entry lines up with ram_rdata1
   logic [RD_LAT-1:0] pv;
   logic [ADDR_W-1:0] paddr [RD_LAT];
   logic [31:0]       pkey  [RD_LAT];
   logic [31:0]       pval  [RD_LAT];
   logic [31:0]       ptime [RD_LAT];

   // Write from two cycles back, which the RAM read also missed
   logic              prev_wren;
   logic [ADDR_W-1:0] prev_wraddr;
   logic [95:0]       prev_wdata;

   logic [ADDR_W-1:0] cur_addr;
   logic [95:0]       eff_bucket;
   logic [95:0]       nb;
   logic              fv;
   logic [31:0]       fkey;
   logic [31:0]       fval;

   logic unused_time_hi;
   assign unused_time_hi = ^ip_addr_in1[127:96];

   assign cur_addr = paddr[RD_LAT-1];

   // Later assignments win: the write currently on the port is newest
   always_comb begin
      eff_bucket = ram_rdata1;
      if (prev_wren && (prev_wraddr == cur_addr))
         eff_bucket = prev_wdata;
      if (ram_wren1 && (ram_wraddr1 == cur_addr))
         eff_bucket = ram_wdata1;
   end

   heavy_part_bucket_update #(
      .LAMBDA (LAMBDA)
   ) u_update (
      .bucket     (eff_bucket),
      .key        (pkey[RD_LAT-1]),
      .value      (pval[RD_LAT-1]),
      .new_bucket (nb),
      .fwd_valid  (fv),
      .fwd_key    (fkey),
      .fwd_value  (fval)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_INIT;
         init_addr       <= '0;
         pv              <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            paddr[i] <= '0;
            pkey[i]  <= '0;
            pval[i]  <= '0;
            ptime[i] <= '0;
         end
         prev_wren       <= 1'b0;
         prev_wraddr     <= '0;
         prev_wdata      <= '0;
         ram_wren1       <= 1'b0;
         ram_wraddr1     <= '0;
         ram_wdata1      <= '0;
         ip_addr_out_wr1 <= 1'b0;
         ip_addr_out1    <= '0;
         ip_addr_in_alf1 <= 1'b0;
      end else begin
         prev_wren   <= ram_wren1;
         prev_wraddr <= ram_wraddr1;
         prev_wdata  <= ram_wdata1;

         // Zero-value records are dropped at the door; INIT ignores input
         pv[0]    <= ip_addr_in_wr1 && (state == ST_RUN) &&
                     (ip_addr_in1[31:0] != 32'd0);
         paddr[0] <= ip_addr_in1[36 +: ADDR_W];
         pkey[0]  <= ip_addr_in1[63:32];
         pval[0]  <= ip_addr_in1[31:0];
         ptime[0] <= ip_addr_in1[95:64];
         for (int i = 1; i < RD_LAT; i++) begin
            pv[i]    <= pv[i-1];
            paddr[i] <= paddr[i-1];
            pkey[i]  <= pkey[i-1];
            pval[i]  <= pval[i-1];
            ptime[i] <= ptime[i-1];
         end

         case (state)
            ST_INIT: begin
               ram_wren1       <= 1'b1;
               ram_wraddr1     <= init_addr;
               ram_wdata1      <= '0;
               ip_addr_out_wr1 <= 1'b0;
               ip_addr_in_alf1 <= 1'b1;
               init_addr       <= init_addr + 1'b1;
               if (init_addr == {ADDR_W{1'b1}})
                  state <= ST_RUN;
            end
            default: begin
               ram_wren1       <= pv[RD_LAT-1];
               ram_wraddr1     <= cur_addr;
               ram_wdata1      <= nb;
               ip_addr_out_wr1 <= pv[RD_LAT-1] && fv;
               ip_addr_out1    <= {fkey, fval, ptime[RD_LAT-1]};
               ip_addr_in_alf1 <= ip_addr_out_alf1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_heavy_part_table_compare1.sv
// tb_heavy_part_table_compare1
// Directed bench for heavy_part_table_compare1 with a RAM1 model
// (write-first, two-cycle read latency) and a scoreboard holding expected
// RAM writes and expected table-2 records.
module tb_heavy_part_table_compare1;

   logic          clk = 1'b0;
   logic          reset;
   logic          ip_addr_in_wr1;
   logic [127:0]  ip_addr_in1;
   logic          ip_addr_in_alf1;
   logic [95:0]   ram_rdata1;
   logic          ram_wren1;
   logic [11:0]   ram_wraddr1;
   logic [95:0]   ram_wdata1;
   logic          ip_addr_out_wr1;
   logic [95:0]   ip_addr_out1;
   logic          ip_addr_out_alf1;

   int checks = 0;
   int errors = 0;

   logic [107:0] wr_q [$];
   logic [95:0]  out_q [$];
   logic [107:0] mon_wr_exp;
   logic [95:0]  mon_out_exp;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   heavy_part_table_compare1 #(
      .LAMBDA (8),
      .ADDR_W (12),
      .RD_LAT (2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .ip_addr_in_wr1   (ip_addr_in_wr1),
      .ip_addr_in1      (ip_addr_in1),
      .ip_addr_in_alf1  (ip_addr_in_alf1),
      .ram_rdata1       (ram_rdata1),
      .ram_wren1        (ram_wren1),
      .ram_wraddr1      (ram_wraddr1),
      .ram_wdata1       (ram_wdata1),
      .ip_addr_out_wr1  (ip_addr_out_wr1),
      .ip_addr_out1     (ip_addr_out1),
      .ip_addr_out_alf1 (ip_addr_out_alf1)
   );

   // ---------------- RAM1 model ----------------
   logic [95:0] mem [0:4095];
   logic [95:0] rd_stage;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom};
      rd_stage   = '0;
      ram_rdata1 = '0;
   end

   always @(posedge clk) begin
      if (ram_wren1) mem[ram_wraddr1] = ram_wdata1;
      rd_stage   <= mem[ip_addr_in1[47:36]];
      ram_rdata1 <= rd_stage;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (ram_wren1) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL ram_write got addr=%h data=%h required no write",
                     ram_wraddr1, ram_wdata1);
         end else begin
            mon_wr_exp = wr_q.pop_front();
            if ({ram_wraddr1, ram_wdata1} !== mon_wr_exp) begin
               errors++;
               $display("FAIL ram_write got addr=%h data=%h required addr=%h data=%h",
                        ram_wraddr1, ram_wdata1, mon_wr_exp[107:96], mon_wr_exp[95:0]);
            end
         end
      end
      if (ip_addr_out_wr1) begin
         checks++;
         if (out_q.size() == 0) begin
            errors++;
            $display("FAIL out_record got %h required no record", ip_addr_out1);
         end else begin
            mon_out_exp = out_q.pop_front();
            if (ip_addr_out1 !== mon_out_exp) begin
               errors++;
               $display("FAIL out_record got %h required %h", ip_addr_out1, mon_out_exp);
            end
         end
      end
   end

   // ---------------- helpers / driver tasks ----------------
   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, exp);
      end
   endtask

   function automatic logic [95:0] bkt(input logic [31:0] k, input logic [31:0] p,
                                       input logic f, input logic [30:0] n);
      return {k, p, f, n};
   endfunction

   task automatic send(input logic [31:0] k, input logic [31:0] v, input logic [63:0] tm,
                       input bit exp_wr, input logic [95:0] exp_bkt,
                       input bit exp_out, input logic [95:0] exp_o);
      if (exp_wr)  wr_q.push_back({k[15:4], exp_bkt});
      if (exp_out) out_q.push_back(exp_o);
      ip_addr_in_wr1 = 1'b1;
      ip_addr_in1    = {tm, k, v};
      @(negedge clk);
      ip_addr_in_wr1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_init_writes();
      for (int i = 0; i < 4096; i++) wr_q.push_back({12'(i), 96'b0});
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, 256'({ram_wren1, ram_wraddr1, ram_wdata1, ip_addr_out_wr1,
                        ip_addr_out1, ip_addr_in_alf1}), 256'd0);
   endtask

   task automatic wait_init_done();
      int n;
      n = 0;
      idle(10);
      check("alf_during_init", 256'(ip_addr_in_alf1), 256'd1);
      while (!(ram_wren1 && ram_wraddr1 == 12'hFFF) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 5000) begin
         errors++;
         $display("FAIL init_timeout got %0d cycles required under 5000", n);
      end
      check("alf_last_init_write", 256'(ip_addr_in_alf1), 256'd1);
      @(negedge clk);
      check("alf_after_init", 256'(ip_addr_in_alf1), 256'd0);
      check("init_writes_all_seen", 256'(wr_q.size()), 256'd0);
   endtask

   // Times: upper word nonzero so only time[31:0] may reach the output
   function automatic logic [63:0] tt(input int n);
      return 64'hA5A5_0000_0000_1000 + 64'(n);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      reset            = 1'b1;
      ip_addr_in_wr1   = 1'b0;
      ip_addr_in1      = '0;
      ip_addr_out_alf1 = 1'b0;
      idle(3);
      check_outputs_zero("reset_state");
      push_init_writes();
      reset = 1'b0;
      wait_init_done();

      // Empty insert, match via s3 forwarding, reject, evict
      send(32'h10, 32'd5,  tt(1), 1, bkt(32'h10, 32'd5, 1'b0, 31'd0),  0, '0);
      send(32'h10, 32'd3,  tt(2), 1, bkt(32'h10, 32'd8, 1'b0, 31'd0),  0, '0);
      send(32'h11, 32'd63, tt(3), 1, bkt(32'h10, 32'd8, 1'b0, 31'd63),
           1, {32'h11, 32'd63, 32'h0000_1003});
      send(32'h11, 32'd1,  tt(4), 1, bkt(32'h11, 32'd1, 1'b1, 31'd1),
           1, {32'h10, 32'd8, 32'h0000_1004});
      idle(5);

      // Distance-2 forwarding via the held previous write
      send(32'h20, 32'd7, tt(5), 1, bkt(32'h20, 32'd7, 1'b0, 31'd0), 0, '0);
      send(32'h30, 32'd1, tt(6), 1, bkt(32'h30, 32'd1, 1'b0, 31'd0), 0, '0);
      send(32'h20, 32'd2, tt(7), 1, bkt(32'h20, 32'd9, 1'b0, 31'd0), 0, '0);
      // Distance 3: the RAM read sees the landed write
      send(32'h40, 32'd4, tt(8),  1, bkt(32'h40, 32'd4, 1'b0, 31'd0), 0, '0);
      send(32'h80, 32'd1, tt(9),  1, bkt(32'h80, 32'd1, 1'b0, 31'd0), 0, '0);
      send(32'h90, 32'd1, tt(10), 1, bkt(32'h90, 32'd1, 1'b0, 31'd0), 0, '0);
      send(32'h40, 32'd1, tt(11), 1, bkt(32'h40, 32'd5, 1'b0, 31'd0), 0, '0);
      idle(5);
      send(32'h20, 32'd1, tt(12), 1, bkt(32'h20, 32'd10, 1'b0, 31'd0), 0, '0);

      // Zero value dropped, then a normal record
      send(32'h70, 32'd0, tt(13), 0, '0, 0, '0);
      send(32'h71, 32'd2, tt(14), 1, bkt(32'h71, 32'd2, 1'b0, 31'd0), 0, '0);
      // Conflict against an evicted (flagged) bucket keeps the flag
      send(32'h10, 32'd2, tt(15), 1, bkt(32'h11, 32'd1, 1'b1, 31'd3),
           1, {32'h10, 32'd2, 32'h0000_100F});
      idle(5);

      // Saturation cases, buckets planted in the RAM model
      mem[5] = bkt(32'h50, 32'hFFFF_FFFE, 1'b0, 31'd0);
      mem[6] = bkt(32'h60, 32'h2000_0000, 1'b0, 31'h7FFF_FFF0);
      send(32'h50, 32'd5,     tt(16), 1, bkt(32'h50, 32'hFFFF_FFFF, 1'b0, 31'd0), 0, '0);
      send(32'h61, 32'h100,   tt(17), 1, bkt(32'h60, 32'h2000_0000, 1'b0, 31'h7FFF_FFFF),
           1, {32'h61, 32'h100, 32'h0000_1011});
      idle(5);

      // Almost-full: registered to alf, in-flight records still emerge
      send(32'hA0, 32'd1, tt(18), 1, bkt(32'hA0, 32'd1, 1'b0, 31'd0), 0, '0);
      ip_addr_out_alf1 = 1'b1;
      check("alf_before_reg", 256'(ip_addr_in_alf1), 256'd0);
      send(32'hB0, 32'd1, tt(19), 1, bkt(32'hB0, 32'd1, 1'b0, 31'd0), 0, '0);
      check("alf_follows_fifo", 256'(ip_addr_in_alf1), 256'd1);
      ip_addr_out_alf1 = 1'b0;
      @(negedge clk);
      check("alf_released", 256'(ip_addr_in_alf1), 256'd0);
      idle(6);
      check("wr_q_drained", 256'(wr_q.size()), 256'd0);
      check("out_q_drained", 256'(out_q.size()), 256'd0);

      // Mid-run reset: in-flight record lost, RAM re-zeroed
      send(32'hC0, 32'd1, tt(20), 0, '0, 0, '0);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset_midrun");
      idle(2);
      push_init_writes();
      reset = 1'b0;
      wait_init_done();
      send(32'h10, 32'd9, tt(21), 1, bkt(32'h10, 32'd9, 1'b0, 31'd0), 0, '0);
      idle(6);
      check("final_wr_q_empty", 256'(wr_q.size()), 256'd0);
      check("final_out_q_empty", 256'(out_q.size()), 256'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
